// File: rtl/freq_duty_meter.sv
// freq_duty_meter
// Reciprocal frequency and duty-cycle meter. The measurement gate opens and
// closes on rising edges of the synchronised input, so every gate spans a
// whole number of signal periods. After the gate closes, one shared serial
// divider computes the frequency and then the duty cycle. The results are
// handed to the downstream sender with a single-cycle meas_valid pulse.

module freq_duty_meter #(
  parameter int unsigned CLK_FREQ       = 32'd50_000_000,
  parameter int unsigned GATE_CYCLES    = 32'd50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        tx_busy,
  output logic [33:0] freq,
  output logic [7:0]  duty,
  output logic [63:0] high_time,
  output logic [63:0] low_time,
  output logic        meas_valid,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    DIV_F = 3'd4,
    DIV_D = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [63:0] CLK_FREQ_W = 64'(CLK_FREQ);
  localparam logic [32:0] GATE_LIM   = 33'(GATE_CYCLES);
  localparam logic [32:0] WAIT_LIM   = 33'(TIMEOUT_CYCLES);
  localparam logic [63:0] FREQ_MAX   = 64'h0000_0003_FFFF_FFFF;
  localparam logic [63:0] DUTY_MAX   = 64'd100;

  // Frequency quotient limited to the 34-bit output range. A zero divisor gives 0.
  function automatic logic [33:0] sat_freq(input logic [63:0] q, input logic [63:0] d);
    logic [33:0] r;
    if (d == 64'd0) begin
      r = 34'd0;
    end else if (q > FREQ_MAX) begin
      r = 34'h3_FFFF_FFFF;
    end else begin
      r = q[33:0];
    end
    return r;
  endfunction

  // Duty quotient limited to 100 percent. A zero divisor gives 0.
  function automatic logic [7:0] clamp_duty(input logic [63:0] q, input logic [63:0] d);
    logic [7:0] r;
    if (d == 64'd0) begin
      r = 8'd0;
    end else if (q > DUTY_MAX) begin
      r = 8'd100;
    end else begin
      r = q[7:0];
    end
    return r;
  endfunction

  // Input synchroniser and edge-detector pipeline.
  logic meta_r;
  logic sync_r;
  logic lvl_r;
  logic prev_r;
  logic rise_s;

  // FSM state, measurement counters and divider registers.
  state_t      state_r;
  logic [63:0] ns_r;
  logic [63:0] nh_r;
  logic [63:0] nx_r;
  logic [31:0] gate_cnt_r;
  logic [31:0] wait_cnt_r;
  logic [5:0]  div_cnt_r;
  logic [63:0] rem_r;
  logic [63:0] dvd_r;

  // Staged results. They are copied to the outputs only when the result is handed off.
  logic [33:0] res_freq_r;
  logic [7:0]  res_duty_r;
  logic [63:0] res_high_r;
  logic [63:0] res_low_r;
  logic        res_to_r;

  // Outputs of one restoring-division step.
  logic [64:0] shifted_s;
  logic [63:0] rem_nxt_s;
  logic [63:0] quo_nxt_s;
  logic        q_bit_s;

  // Wait counters compared one step ahead, so the limit is reached on the last allowed cycle.
  logic gate_hit_s;
  logic wait_hit_s;

  // Two-flop synchroniser followed by a level/previous-level pair. Both edges see the same 3-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      lvl_r  <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= sig_in;
      sync_r <= meta_r;
      lvl_r  <= sync_r;
      prev_r <= lvl_r;
    end
  end

  assign rise_s = lvl_r & ~prev_r;

  // One quotient bit per cycle. dvd_r shifts out dividend bits and shifts in quotient bits.
  always_comb begin
    shifted_s = {rem_r, dvd_r[63]};
    if (shifted_s >= {1'b0, ns_r}) begin
      rem_nxt_s = shifted_s[63:0] - ns_r;
      q_bit_s   = 1'b1;
    end else begin
      rem_nxt_s = shifted_s[63:0];
      q_bit_s   = 1'b0;
    end
    quo_nxt_s = {dvd_r[62:0], q_bit_s};
  end

  // Threshold detection for the gate length and the edge-wait timeout.
  always_comb begin
    if (({1'b0, gate_cnt_r} + 33'd1) >= GATE_LIM) begin
      gate_hit_s = 1'b1;
    end else begin
      gate_hit_s = 1'b0;
    end
    if (({1'b0, wait_cnt_r} + 33'd1) >= WAIT_LIM) begin
      wait_hit_s = 1'b1;
    end else begin
      wait_hit_s = 1'b0;
    end
  end

  // Measurement sequencer: gate control, counting, serial division and result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ns_r       <= 64'd0;
      nh_r       <= 64'd0;
      nx_r       <= 64'd0;
      gate_cnt_r <= 32'd0;
      wait_cnt_r <= 32'd0;
      div_cnt_r  <= 6'd0;
      rem_r      <= 64'd0;
      dvd_r      <= 64'd0;
      res_freq_r <= 34'd0;
      res_duty_r <= 8'd0;
      res_high_r <= 64'd0;
      res_low_r  <= 64'd0;
      res_to_r   <= 1'b0;
      freq       <= 34'd0;
      duty       <= 8'd0;
      high_time  <= 64'd0;
      low_time   <= 64'd0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          ns_r       <= 64'd0;
          nh_r       <= 64'd0;
          nx_r       <= 64'd0;
          gate_cnt_r <= 32'd0;
          wait_cnt_r <= 32'd0;
          busy       <= 1'b1;
          state_r    <= ARM;
        end
        ARM: begin
          if (rise_s) begin
            // The opening edge cycle is the first counted cycle and the start of the first period.
            ns_r       <= 64'd1;
            nh_r       <= {63'd0, lvl_r};
            nx_r       <= 64'd1;
            gate_cnt_r <= 32'd1;
            wait_cnt_r <= 32'd0;
            if (GATE_LIM <= 33'd1) begin
              state_r <= CLOSE;
            end else begin
              state_r <= GATE;
            end
          end else if (wait_hit_s) begin
            res_freq_r <= 34'd0;
            res_duty_r <= lvl_r ? 8'd100 : 8'd0;
            res_high_r <= 64'd0;
            res_low_r  <= 64'd0;
            res_to_r   <= 1'b1;
            state_r    <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        GATE: begin
          ns_r       <= ns_r + 64'd1;
          nh_r       <= nh_r + {63'd0, lvl_r};
          nx_r       <= nx_r + {63'd0, rise_s};
          gate_cnt_r <= gate_cnt_r + 32'd1;
          if (gate_hit_s) begin
            wait_cnt_r <= 32'd0;
            state_r    <= CLOSE;
          end
        end
        CLOSE: begin
          if (rise_s) begin
            // The closing edge is excluded. Start the frequency division from here.
            dvd_r     <= nx_r * CLK_FREQ_W;
            rem_r     <= 64'd0;
            div_cnt_r <= 6'd0;
            state_r   <= DIV_F;
          end else if (wait_hit_s) begin
            res_freq_r <= 34'd0;
            res_duty_r <= lvl_r ? 8'd100 : 8'd0;
            res_high_r <= 64'd0;
            res_low_r  <= 64'd0;
            res_to_r   <= 1'b1;
            state_r    <= DONE;
          end else begin
            ns_r       <= ns_r + 64'd1;
            nh_r       <= nh_r + {63'd0, lvl_r};
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        DIV_F: begin
          rem_r     <= rem_nxt_s;
          dvd_r     <= quo_nxt_s;
          div_cnt_r <= div_cnt_r + 6'd1;
          if (div_cnt_r == 6'd63) begin
            res_freq_r <= sat_freq(quo_nxt_s, ns_r);
            dvd_r      <= nh_r * 64'd100;
            rem_r      <= 64'd0;
            div_cnt_r  <= 6'd0;
            state_r    <= DIV_D;
          end
        end
        DIV_D: begin
          rem_r     <= rem_nxt_s;
          dvd_r     <= quo_nxt_s;
          div_cnt_r <= div_cnt_r + 6'd1;
          if (div_cnt_r == 6'd63) begin
            res_duty_r <= clamp_duty(quo_nxt_s, ns_r);
            res_high_r <= nh_r;
            res_low_r  <= ns_r - nh_r;
            res_to_r   <= 1'b0;
            div_cnt_r  <= 6'd0;
            state_r    <= DONE;
          end
        end
        DONE: begin
          if (!tx_busy) begin
            freq       <= res_freq_r;
            duty       <= res_duty_r;
            high_time  <= res_high_r;
            low_time   <= res_low_r;
            timeout    <= res_to_r;
            meas_valid <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_duty_meter.sv
// Testbench for freq_duty_meter. Periodic and constant waveforms drive the
// input. An arithmetic model of a gate aligned to whole signal periods
// supplies the expected results. One per-cycle compare step checks the
// reset state, the result values, the hold behaviour and the stall rules.

module tb_freq_duty_meter;

  localparam longint CLK_HZ = 64'd50_000_000;
  localparam int     G      = 500;
  localparam int     TO     = 2000;
  localparam int     BOUND  = 3 * TO + G + 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        tx_busy = 1'b0;
  logic [33:0] freq;
  logic [7:0]  duty;
  logic [63:0] high_time;
  logic [63:0] low_time;
  logic        meas_valid;
  logic        timeout;
  logic        busy;

  freq_duty_meter #(
    .CLK_FREQ(32'd50_000_000),
    .GATE_CYCLES(32'd500),
    .TIMEOUT_CYCLES(32'd2000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .tx_busy(tx_busy),
    .freq(freq),
    .duty(duty),
    .high_time(high_time),
    .low_time(low_time),
    .meas_valid(meas_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Waveform generator: mode 0 holds the input low, mode 1 holds it high, mode 2 gives period gen_p with gen_h high cycles.
  int gen_mode = 2;
  int gen_p = 100;
  int gen_h = 30;
  int phase = 0;

  always @(negedge clk) begin
    case (gen_mode)
      0: sig_in <= 1'b0;
      1: sig_in <= 1'b1;
      default: begin
        sig_in <= (phase < gen_h);
        phase  <= (phase + 1 >= gen_p) ? 0 : phase + 1;
      end
    endcase
  end

  int     checks = 0;
  int     errors = 0;
  int     mv_count = 0;
  bit     exp_on = 1'b0;
  longint exp_f, exp_d, exp_hi, exp_lo;
  bit     exp_to;
  logic [33:0] h_freq = '0;
  logic [7:0]  h_duty = '0;
  logic [63:0] h_high = '0;
  logic [63:0] h_low = '0;
  logic        h_to = 1'b0;
  bit          prev_mv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected results for a periodic input: the gate covers ceil(G/p) whole periods.
  task automatic model(input int p, input int h, output longint f, output longint d,
                       output longint hi, output longint lo);
    longint nx, ns, nh;
    nx = (longint'(G) + longint'(p) - 1) / longint'(p);
    ns = nx * longint'(p);
    nh = nx * longint'(h);
    f  = (nx * CLK_HZ) / ns;
    if (f > 64'h3_FFFF_FFFF) f = 64'h3_FFFF_FFFF;
    d  = (nh * 100) / ns;
    if (d > 100) d = 100;
    hi = nh;
    lo = ns - nh;
  endtask

  // Advance one clock and check the DUT outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      chk("reset_outputs_zero", 64'(|{freq, duty, high_time, low_time, meas_valid, timeout, busy}), 64'd0);
      h_freq = '0; h_duty = '0; h_high = '0; h_low = '0; h_to = 1'b0;
      prev_mv = 1'b0;
    end else begin
      if (prev_mv) chk("busy_after_valid", 64'(busy), 64'd1);
      if (meas_valid) begin
        mv_count++;
        chk("valid_while_tx_busy", 64'(tx_busy), 64'd0);
        chk("busy_in_valid_cycle", 64'(busy), 64'd0);
        if (exp_on) begin
          chk("freq", 64'(freq), 64'(exp_f));
          chk("duty", 64'(duty), 64'(exp_d));
          chk("high_time", high_time, 64'(exp_hi));
          chk("low_time", low_time, 64'(exp_lo));
          chk("timeout", 64'(timeout), 64'(exp_to));
        end
        h_freq = freq; h_duty = duty; h_high = high_time; h_low = low_time; h_to = timeout;
      end else begin
        chk("outputs_held", ((freq == h_freq) && (duty == h_duty) && (high_time == h_high) &&
                             (low_time == h_low) && (timeout == h_to)) ? 64'd0 : 64'd1, 64'd0);
      end
      prev_mv = meas_valid;
    end
  endtask

  // Step until the next meas_valid or until the cycle budget runs out.
  task automatic wait_result(input int bound, output int n);
    int start;
    start = mv_count;
    n = 0;
    while (mv_count == start && n < bound) begin
      step();
      n++;
    end
    chk("result_arrival", 64'(mv_count - start), 64'd1);
  endtask

  // Switch the waveform, drop the first result (the gate may straddle the switch) and check the next one.
  task automatic run_cfg(input int mode, input int p, input int h, input longint f, input longint d,
                         input longint hi, input longint lo, input bit to, output int n);
    gen_mode = mode;
    gen_p = p;
    gen_h = h;
    exp_on = 1'b0;
    wait_result(BOUND, n);
    exp_f = f; exp_d = d; exp_hi = hi; exp_lo = lo; exp_to = to;
    exp_on = 1'b1;
    wait_result(BOUND, n);
  endtask

  initial begin
    int n, start, k, p, h;
    longint f, d, hi, lo;

    repeat (4) step();
    rst_n = 1'b1;

    // Hand-computed values that pin the model.
    model(100, 30, f, d, hi, lo);
    chk("model_p100_f", 64'(f), 64'd500_000);
    chk("model_p100_d", 64'(d), 64'd30);
    chk("model_p100_hi", 64'(hi), 64'd150);
    chk("model_p100_lo", 64'(lo), 64'd350);
    model(333, 167, f, d, hi, lo);
    chk("model_p333_f", 64'(f), 64'd150_150);
    chk("model_p333_d", 64'(d), 64'd50);
    chk("model_p333_lo", 64'(lo), 64'd332);
    model(2, 1, f, d, hi, lo);
    chk("model_p2_f", 64'(f), 64'd25_000_000);
    chk("model_p2_d", 64'(d), 64'd50);

    // Directed periodic cases, including a back-to-back repeat.
    run_cfg(2, 100, 30, 500_000, 30, 150, 350, 1'b0, n);
    wait_result(BOUND, n);
    run_cfg(2, 333, 167, 150_150, 50, 334, 332, 1'b0, n);
    run_cfg(2, 700, 1, 71_428, 0, 1, 699, 1'b0, n);
    run_cfg(2, 2, 1, 25_000_000, 50, 250, 250, 1'b0, n);
    wait_result(BOUND, n);

    // No edges at all: a timeout result, with duty at 100 when the input is stuck high.
    run_cfg(0, 100, 30, 0, 0, 0, 0, 1'b1, n);
    chk("timeout_wait_low_min", (n >= TO) ? 64'd1 : 64'd0, 64'd1);
    run_cfg(1, 100, 30, 0, 100, 0, 0, 1'b1, n);
    chk("timeout_wait_high_min", (n >= TO) ? 64'd1 : 64'd0, 64'd1);

    // Downstream stall: hold tx_busy through DONE, then release it.
    run_cfg(2, 100, 30, 500_000, 30, 150, 350, 1'b0, n);
    tx_busy = 1'b1;
    start = mv_count;
    repeat (1500) step();
    chk("stall_no_valid", 64'(mv_count - start), 64'd0);
    tx_busy = 1'b0;
    wait_result(4, n);
    chk("release_latency", 64'(n), 64'd1);
    start = mv_count;
    repeat (300) step();
    chk("single_pulse_after_release", 64'(mv_count - start), 64'd0);

    // Reset mid-gate, released while the input is low, then one clean measurement.
    repeat (50) step();
    rst_n = 1'b0;
    repeat (3) step();
    k = 0;
    while (phase != 40 && k < 300) begin
      step();
      k++;
    end
    rst_n = 1'b1;
    start = mv_count;
    repeat (20) step();
    chk("no_valid_after_reset", 64'(mv_count - start), 64'd0);
    wait_result(BOUND, n);

    // Randomised periodic waveforms.
    for (int i = 0; i < 12; i++) begin
      p = int'($urandom_range(150, 2));
      h = int'($urandom_range(p - 1, 1));
      model(p, h, f, d, hi, lo);
      run_cfg(2, p, h, f, d, hi, lo, 1'b0, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
